// File: rtl/pc_16_if.sv
// pc_16_if: instruction-fetch PC bus (jump/call target, control strobes, PC and stack status).
interface pc_16_if;
   localparam int unsigned W = 16;

   logic [W-1:0] in;
   logic         load;
   logic         inc;
   logic         call;
   logic         ret;
   logic [W-1:0] out;
   logic         stack_full;
   logic         stack_empty;
   logic         stack_err;

   modport master (
      output in, load, inc, call, ret,
      input  out, stack_full, stack_empty, stack_err
   );

   modport slave (
      input  in, load, inc, call, ret,
      output out, stack_full, stack_empty, stack_err
   );
endinterface

// File: rtl/pc_16.sv
// pc_16: 16-bit program counter with load/increment/hold and an optional
// hardware return-address stack enabled by defining RET_STACK_EN.
// Priority per cycle: load > call > ret > inc > hold.
module pc_16 #(
   parameter logic [15:0]  RESET_ADDR = 16'h0000,
   parameter int unsigned  DEPTH      = 4
) (
   input  logic   clk,
   input  logic   rst,
   pc_16_if.slave bus
);

   localparam int unsigned W = 16;

   logic [W-1:0] pc_q;
   logic [W-1:0] pc_inc;

   // Modular increment; FFFF rolls over to 0000 silently.
   assign pc_inc  = pc_q + W'(1);
   assign bus.out = pc_q;

`ifdef RET_STACK_EN
   localparam int unsigned IW  = $clog2(DEPTH);
   localparam int unsigned SPW = IW + 1;

   logic [W-1:0]   stack_q [DEPTH];
   logic [SPW-1:0] sp_q;
   logic           err_q;
   logic           full;
   logic           empty;
   logic [IW-1:0]  push_idx;
   logic [IW-1:0]  pop_idx;
   logic           do_push;

   // Status flags decoded from the registered stack pointer.
   assign full     = (sp_q == SPW'(DEPTH));
   assign empty    = (sp_q == '0);
   assign push_idx = IW'(sp_q);
   assign pop_idx  = IW'(sp_q - SPW'(1));
   assign do_push  = !bus.load && bus.call && !full;

   assign bus.stack_full  = full;
   assign bus.stack_empty = empty;
   assign bus.stack_err   = err_q;

   // PC, stack pointer and sticky error update with load > call > ret > inc priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q  <= RESET_ADDR;
         sp_q  <= '0;
         err_q <= 1'b0;
      end else if (bus.load) begin
         pc_q <= bus.in;
      end else if (bus.call) begin
         if (!full) begin
            sp_q <= sp_q + SPW'(1);
            pc_q <= bus.in;
         end else begin
            err_q <= 1'b1;
         end
      end else if (bus.ret) begin
         if (!empty) begin
            sp_q <= sp_q - SPW'(1);
            pc_q <= stack_q[pop_idx];
         end else begin
            err_q <= 1'b1;
         end
      end else if (bus.inc) begin
         pc_q <= pc_inc;
      end
   end

   // Return-address storage; deliberately not reset, entries above sp are dead.
   always_ff @(posedge clk) begin
      if (!rst && do_push) begin
         stack_q[push_idx] <= pc_inc;
      end
   end
`else
   logic unused_stack_ctl;

   // Without the stack, call/ret have no effect.
   assign unused_stack_ctl = &{1'b0, bus.call, bus.ret};

   assign bus.stack_full  = 1'b0;
   assign bus.stack_empty = 1'b1;
   assign bus.stack_err   = 1'b0;

   // PC update with load > inc > hold priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= RESET_ADDR;
      end else if (bus.load) begin
         pc_q <= bus.in;
      end else if (bus.inc) begin
         pc_q <= pc_inc;
      end
   end
`endif

endmodule

// File: tb/tb_pc_16.sv
// tb_pc_16: table-driven scoreboard bench for pc_16 (both RET_STACK_EN builds).
module tb_pc_16;

   typedef struct {
      string       name;
      logic [15:0] in;
      logic        load;
      logic        inc;
      logic        call;
      logic        ret;
      logic [15:0] exp_out;
      logic [2:0]  exp_st;   // {stack_full, stack_empty, stack_err}
   } vec_t;

   typedef struct {
      string       name;
      logic [15:0] out;
      logic [2:0]  st;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;
   vec_t vecs [$];
   exp_t sb   [$];

   pc_16_if bus ();

   pc_16 dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: out got %h want %h", name, act, exp);
      end
   endtask

   task automatic check3(input string name, input logic [2:0] act, input logic [2:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: {full,empty,err} got %b want %b", name, act, exp);
      end
   endtask

   function automatic logic [2:0] status();
      return {bus.stack_full, bus.stack_empty, bus.stack_err};
   endfunction

   task automatic drive(input logic [15:0] in, input logic load, input logic inc,
                        input logic call, input logic ret);
      bus.in   = in;
      bus.load = load;
      bus.inc  = inc;
      bus.call = call;
      bus.ret  = ret;
   endtask

   // Drive one vector on the falling edge, check one cycle later (1-cycle latency).
   task automatic apply(input vec_t v);
      exp_t e;
      @(negedge clk);
      drive(v.in, v.load, v.inc, v.call, v.ret);
      sb.push_back('{name: v.name, out: v.exp_out, st: v.exp_st});
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s: scoreboard empty", v.name);
      end else begin
         e = sb.pop_front();
         check16(e.name, bus.out, e.out);
         check3({e.name, "_st"}, status(), e.st);
      end
   endtask

   function automatic vec_t mk(input string name, input logic [15:0] in, input logic load,
                               input logic inc, input logic call, input logic ret,
                               input logic [15:0] exp_out, input logic [2:0] exp_st);
      vec_t v;
      v.name = name; v.in = in; v.load = load; v.inc = inc; v.call = call; v.ret = ret;
      v.exp_out = exp_out; v.exp_st = exp_st;
      return v;
   endfunction

   initial begin
      drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      check16("reset_out", bus.out, 16'h0000);
      check3("reset_st", status(), 3'b010);

      // Async reset mid-cycle with inc high: PC returns to 0000 with no clock edge.
      @(negedge clk);
      rst = 1'b0;
      apply(mk("pre_load", 16'h55AA, 1, 0, 0, 0, 16'h55AA, 3'b010));
      @(negedge clk);
      bus.load = 1'b0;
      bus.inc  = 1'b1;
      #2 rst = 1'b1;
      #1;
      check16("async_rst_out", bus.out, 16'h0000);
      check3("async_rst_st", status(), 3'b010);
      #1;
      bus.inc = 1'b0;
      rst     = 1'b0;

      vecs.push_back(mk("inc1", 16'h0000, 0, 1, 0, 0, 16'h0001, 3'b010));
      vecs.push_back(mk("inc2", 16'h0000, 0, 1, 0, 0, 16'h0002, 3'b010));
      vecs.push_back(mk("inc3", 16'h0000, 0, 1, 0, 0, 16'h0003, 3'b010));
      vecs.push_back(mk("load_fffe", 16'hFFFE, 1, 0, 0, 0, 16'hFFFE, 3'b010));
      vecs.push_back(mk("inc_ffff", 16'h0000, 0, 1, 0, 0, 16'hFFFF, 3'b010));
      vecs.push_back(mk("inc_wrap", 16'h0000, 0, 1, 0, 0, 16'h0000, 3'b010));
      vecs.push_back(mk("load_prio", 16'h1234, 1, 1, 0, 0, 16'h1234, 3'b010));
      vecs.push_back(mk("hold", 16'hBEEF, 0, 0, 0, 0, 16'h1234, 3'b010));
`ifdef RET_STACK_EN
      vecs.push_back(mk("load_0010", 16'h0010, 1, 0, 0, 0, 16'h0010, 3'b010));
      vecs.push_back(mk("call_0100", 16'h0100, 0, 0, 1, 0, 16'h0100, 3'b000));
      vecs.push_back(mk("ret_0011", 16'h0000, 0, 0, 0, 1, 16'h0011, 3'b010));
      vecs.push_back(mk("load_over_call", 16'h0300, 1, 0, 1, 1, 16'h0300, 3'b010));
      vecs.push_back(mk("call_over_ret", 16'h0400, 0, 1, 1, 1, 16'h0400, 3'b000));
      vecs.push_back(mk("call_0500", 16'h0500, 0, 0, 1, 0, 16'h0500, 3'b000));
      vecs.push_back(mk("call_0600", 16'h0600, 0, 0, 1, 0, 16'h0600, 3'b000));
      vecs.push_back(mk("call_full", 16'h0700, 0, 0, 1, 0, 16'h0700, 3'b100));
      vecs.push_back(mk("call_ovf", 16'h0ABC, 0, 0, 1, 0, 16'h0700, 3'b101));
      vecs.push_back(mk("ret_0601", 16'h0000, 0, 0, 0, 1, 16'h0601, 3'b001));
      vecs.push_back(mk("ret_0501", 16'h0000, 0, 0, 0, 1, 16'h0501, 3'b001));
      vecs.push_back(mk("ret_0401", 16'h0000, 0, 0, 0, 1, 16'h0401, 3'b001));
      vecs.push_back(mk("ret_0301", 16'h0000, 0, 0, 0, 1, 16'h0301, 3'b011));
      vecs.push_back(mk("ret_unf", 16'h0000, 0, 0, 0, 1, 16'h0301, 3'b011));
      vecs.push_back(mk("ret_over_inc", 16'h0000, 0, 1, 0, 1, 16'h0301, 3'b011));
      vecs.push_back(mk("inc_err_sticky", 16'h0000, 0, 1, 0, 0, 16'h0302, 3'b011));
`else
      vecs.push_back(mk("call_ignored", 16'h0200, 0, 0, 1, 0, 16'h1234, 3'b010));
      vecs.push_back(mk("ret_ignored", 16'h0000, 0, 0, 0, 1, 16'h1234, 3'b010));
      vecs.push_back(mk("inc_with_call", 16'h0200, 0, 1, 1, 1, 16'h1235, 3'b010));
      vecs.push_back(mk("load_with_call", 16'h0777, 1, 0, 1, 0, 16'h0777, 3'b010));
`endif

      foreach (vecs[i]) apply(vecs[i]);

`ifdef RET_STACK_EN
      // Only reset clears the sticky error; stack pointer returns to empty.
      @(negedge clk);
      drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      check16("rst_clear_out", bus.out, 16'h0000);
      check3("rst_clear_st", status(), 3'b010);
      @(negedge clk);
      rst = 1'b0;
      apply(mk("ret_after_rst", 16'h0000, 0, 0, 0, 1, 16'h0000, 3'b011));
`endif

      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
